// File: rtl/prog_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : prog_interrupt_controller
// Purpose  : Clocked programmable interrupt controller with masking, edge or
//            level triggering, fixed/rotating priority, EOI and auto-EOI.
// Revision : 1.0 - initial release
// ============================================================================
module prog_interrupt_controller #(
  parameter int         NUM_IRQ   = 8,
  parameter int         ID_W      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
  parameter logic [7:0] VBASE_RST = 8'h20
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_IRQ-1:0] IR,
  input  logic               CS,
  input  logic               WR,
  input  logic               RD,
  input  logic [1:0]         A,
  input  logic [7:0]         DIN,
  output logic [7:0]         DOUT,
  output logic               DOUT_EN,
  output logic               INT,
  input  logic               INTA
);

  localparam logic [2:0] c_CMD_NS_EOI     = 3'b001;
  localparam logic [2:0] c_CMD_TRIG       = 3'b010;
  localparam logic [2:0] c_CMD_SP_EOI     = 3'b011;
  localparam logic [2:0] c_CMD_FIXED      = 3'b100;
  localparam logic [2:0] c_CMD_NS_EOI_ROT = 3'b101;
  localparam logic [2:0] c_CMD_ROTATE     = 3'b110;
  localparam logic [2:0] c_CMD_AEOI       = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK1 = 2'd1,
    S_ACK2 = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] irr_q, irr_d, isr_q, isr_d, imr_q, imr_d;
  logic [NUM_IRQ-1:0] ir_q;
  logic [7:0]         vbase_q, vbase_d, dout_q, dout_d;
  logic               level_q, level_d, rot_q, rot_d, aeoi_q, aeoi_d;
  logic [ID_W-1:0]    low_q, low_d, id_q, id_d;
  logic               spur_q, spur_d, int_q, int_d, dout_en_q, dout_en_d;
  logic               inta_low_q, wr_act_q;

  logic               w_inta_edge, w_wr_act, w_wr_stb, w_rd_act;
  int                 w_isr_top, w_isr_rank, w_req_top;
  logic               w_isr_vld, w_req_vld;
  logic [ID_W-1:0]    w_isr_id, w_req_id;
  logic [2:0]         w_id3, w_low3;
  logic [7:0]         w_rd_data;
  logic [NUM_IRQ-1:0] w_ack_set, w_eoi_clr, w_aeoi_clr, w_irr_trig;

  // Rank 0 is the highest priority; rotation places lowest_prio at rank N-1.
  function automatic int prio_rank(input int idx, input logic rot, input int low);
    int r;
    if (!rot) return idx;
    r = idx - low - 1;
    if (r < 0) r = r + NUM_IRQ;
    return r;
  endfunction

  function automatic int best_id(input logic [NUM_IRQ-1:0] v, input logic rot,
                                 input int low, input int limit);
    int best;
    int best_r;
    best   = -1;
    best_r = limit;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (v[i] && (prio_rank(i, rot, low) < best_r)) begin
        best   = i;
        best_r = prio_rank(i, rot, low);
      end
    end
    return best;
  endfunction

  assign w_inta_edge = ~INTA & ~inta_low_q;
  assign w_wr_act    = ~CS & ~WR;
  assign w_wr_stb    = w_wr_act & ~wr_act_q;
  assign w_rd_act    = ~CS & ~RD;
  assign w_irr_trig  = level_q ? IR : (irr_q | (IR & ~ir_q));

  // A request only wins if it outranks everything currently in service.
  always_comb begin
    w_isr_top  = best_id(isr_q, rot_q, int'(low_q), NUM_IRQ);
    w_isr_vld  = (w_isr_top >= 0);
    w_isr_rank = w_isr_vld ? prio_rank(w_isr_top, rot_q, int'(low_q)) : NUM_IRQ;
    w_req_top  = best_id(irr_q & ~imr_q, rot_q, int'(low_q), w_isr_rank);
    w_req_vld  = (w_req_top >= 0);
    w_isr_id   = ID_W'(w_isr_top);
    w_req_id   = ID_W'(w_req_top);
  end

  always_comb begin
    w_id3                = 3'd0;
    w_id3[ID_W-1:0]      = id_q;
    w_low3               = 3'd0;
    w_low3[ID_W-1:0]     = low_q;
    w_rd_data            = 8'd0;
    case (A)
      2'd0:    w_rd_data[NUM_IRQ-1:0] = irr_q;
      2'd1:    w_rd_data[NUM_IRQ-1:0] = isr_q;
      2'd2:    w_rd_data[NUM_IRQ-1:0] = imr_q;
      default: w_rd_data = {rot_q, aeoi_q, level_q, 2'b00, w_low3};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    imr_d      = imr_q;
    vbase_d    = vbase_q;
    level_d    = level_q;
    rot_d      = rot_q;
    aeoi_d     = aeoi_q;
    low_d      = low_q;
    id_d       = id_q;
    spur_d     = spur_q;
    dout_d     = dout_q;
    dout_en_d  = 1'b0;
    int_d      = 1'b0;
    w_ack_set  = '0;
    w_eoi_clr  = '0;
    w_aeoi_clr = '0;

    if (w_wr_stb) begin
      case (A)
        2'd0: begin
          case (DIN[7:5])
            c_CMD_NS_EOI, c_CMD_NS_EOI_ROT: begin
              if (w_isr_vld) begin
                w_eoi_clr[w_isr_id] = 1'b1;
                if (DIN[7:5] == c_CMD_NS_EOI_ROT) low_d = w_isr_id;
              end
            end
            c_CMD_SP_EOI: begin
              if (int'(DIN[ID_W-1:0]) < NUM_IRQ) w_eoi_clr[DIN[ID_W-1:0]] = 1'b1;
            end
            c_CMD_FIXED:  rot_d   = 1'b0;
            c_CMD_ROTATE: rot_d   = 1'b1;
            c_CMD_TRIG:   level_d = DIN[0];
            c_CMD_AEOI:   aeoi_d  = DIN[0];
            default: ;
          endcase
        end
        2'd1:    imr_d   = DIN[NUM_IRQ-1:0];
        2'd2:    vbase_d = DIN;
        default: ;
      endcase
    end

    // Acknowledge handling comes last so auto-EOI rotation wins a same-cycle tie.
    unique case (state_q)
      S_IDLE: begin
        if (w_inta_edge) begin
          state_d = S_ACK1;
          if (w_req_vld) begin
            id_d                = w_req_id;
            spur_d              = 1'b0;
            w_ack_set[w_req_id] = 1'b1;
          end else begin
            id_d   = ID_W'(NUM_IRQ - 1);
            spur_d = 1'b1;
          end
        end else begin
          int_d = w_req_vld;
          if (w_rd_act) begin
            dout_d    = w_rd_data;
            dout_en_d = 1'b1;
          end
        end
      end
      S_ACK1: begin
        if (w_inta_edge) begin
          state_d   = S_ACK2;
          dout_d    = {vbase_q[7:3], w_id3};
          dout_en_d = 1'b1;
        end
      end
      S_ACK2: begin
        if (INTA) begin
          state_d = S_IDLE;
          if (aeoi_q && !spur_q) begin
            w_aeoi_clr[id_q] = 1'b1;
            if (rot_q) low_d = id_q;
          end
        end else begin
          dout_en_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    irr_d = w_irr_trig & ~w_ack_set;
    isr_d = (isr_q & ~(w_eoi_clr | w_aeoi_clr)) | w_ack_set;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      irr_q      <= '0;
      isr_q      <= '0;
      imr_q      <= '0;
      ir_q       <= '0;
      vbase_q    <= VBASE_RST;
      level_q    <= 1'b0;
      rot_q      <= 1'b0;
      aeoi_q     <= 1'b0;
      low_q      <= ID_W'(NUM_IRQ - 1);
      id_q       <= '0;
      spur_q     <= 1'b0;
      int_q      <= 1'b0;
      dout_q     <= 8'd0;
      dout_en_q  <= 1'b0;
      inta_low_q <= 1'b0;
      wr_act_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      irr_q      <= irr_d;
      isr_q      <= isr_d;
      imr_q      <= imr_d;
      ir_q       <= IR;
      vbase_q    <= vbase_d;
      level_q    <= level_d;
      rot_q      <= rot_d;
      aeoi_q     <= aeoi_d;
      low_q      <= low_d;
      id_q       <= id_d;
      spur_q     <= spur_d;
      int_q      <= int_d;
      dout_q     <= dout_d;
      dout_en_q  <= dout_en_d;
      inta_low_q <= ~INTA;
      wr_act_q   <= w_wr_act;
    end
  end

  assign DOUT    = dout_q;
  assign DOUT_EN = dout_en_q;
  assign INT     = int_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_interrupt_controller
// Purpose  : Directed stimulus with a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_interrupt_controller;
  localparam int N = 8;

  logic         CLK = 1'b0;
  logic         RST_N, CS, WR, RD, INTA;
  logic [N-1:0] IR;
  logic [1:0]   A;
  logic [7:0]   DIN;
  logic [7:0]   DOUT;
  logic         DOUT_EN, INT;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  prog_interrupt_controller #(.NUM_IRQ(N)) dut (
    .CLK(CLK), .RST_N(RST_N), .IR(IR), .CS(CS), .WR(WR), .RD(RD), .A(A),
    .DIN(DIN), .DOUT(DOUT), .DOUT_EN(DOUT_EN), .INT(INT), .INTA(INTA)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  bit         m_irr[N], m_isr[N], m_imr[N], m_ir_prev[N];
  bit         m_level, m_rot, m_aeoi, m_spur, m_inta_was_low, m_wr_was;
  bit         m_int, m_den;
  int         m_low, m_id, m_acks;
  logic [7:0] m_vbase, m_dout;

  // k-th entry of the current priority order (k=0 is served first)
  function automatic int order_at(input int k);
    return m_rot ? ((m_low + 1 + k) % N) : k;
  endfunction

  always @(posedge CLK) begin
    int isr_pos, win, top;
    bit fall, wr_now, o_aeoi, o_rot;
    logic [7:0] rdata, vec;
    if (!RST_N) begin
      for (int i = 0; i < N; i++) begin
        m_irr[i] = 0; m_isr[i] = 0; m_imr[i] = 0; m_ir_prev[i] = 0;
      end
      m_level = 0; m_rot = 0; m_aeoi = 0; m_spur = 0; m_low = N - 1; m_id = 0;
      m_acks = 0; m_vbase = 8'h20; m_int = 0; m_den = 0; m_dout = 8'h00;
      m_inta_was_low = 0; m_wr_was = 0;
    end else begin
      fall   = !INTA && !m_inta_was_low;
      wr_now = !CS && !WR && !m_wr_was;
      o_aeoi = m_aeoi;
      o_rot  = m_rot;
      isr_pos = N;
      for (int k = N - 1; k >= 0; k--) if (m_isr[order_at(k)]) isr_pos = k;
      win = -1;
      for (int k = isr_pos - 1; k >= 0; k--)
        if (m_irr[order_at(k)] && !m_imr[order_at(k)]) win = order_at(k);
      top = (isr_pos < N) ? order_at(isr_pos) : -1;
      rdata = 8'h00;
      for (int i = 0; i < N; i++) begin
        if (A == 2'd0) rdata[i] = m_irr[i];
        if (A == 2'd1) rdata[i] = m_isr[i];
        if (A == 2'd2) rdata[i] = m_imr[i];
      end
      if (A == 2'd3) rdata = {m_rot, m_aeoi, m_level, 2'b00, 3'(m_low)};
      vec = {m_vbase[7:3], 3'(m_id)};

      for (int i = 0; i < N; i++)
        m_irr[i] = m_level ? IR[i] : (m_irr[i] || (IR[i] && !m_ir_prev[i]));

      if (wr_now) begin
        if (A == 2'd0) begin
          case (DIN[7:5])
            3'b001, 3'b101: if (top >= 0) begin
              m_isr[top] = 0;
              if (DIN[7:5] == 3'b101) m_low = top;
            end
            3'b011: m_isr[DIN[2:0]] = 0;
            3'b100: m_rot = 0;
            3'b110: m_rot = 1;
            3'b010: m_level = DIN[0];
            3'b111: m_aeoi = DIN[0];
            default: ;
          endcase
        end else if (A == 2'd1) begin
          for (int i = 0; i < N; i++) m_imr[i] = DIN[i];
        end else if (A == 2'd2) begin
          m_vbase = DIN;
        end
      end

      m_int = 0;
      m_den = 0;
      if (m_acks == 0) begin
        if (fall) begin
          m_acks = 1;
          if (win >= 0) begin
            m_id = win; m_spur = 0; m_isr[win] = 1; m_irr[win] = 0;
          end else begin
            m_id = N - 1; m_spur = 1;
          end
        end else begin
          m_int = (win >= 0);
          if (!CS && !RD) begin m_dout = rdata; m_den = 1; end
        end
      end else if (m_acks == 1) begin
        if (fall) begin m_acks = 2; m_dout = vec; m_den = 1; end
      end else begin
        if (INTA) begin
          m_acks = 0;
          if (o_aeoi && !m_spur) begin
            m_isr[m_id] = 0;
            if (o_rot) m_low = m_id;
          end
        end else begin
          m_den = 1;
        end
      end

      for (int i = 0; i < N; i++) m_ir_prev[i] = IR[i];
      m_inta_was_low = !INTA;
      m_wr_was       = !CS && !WR;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("model_INT", {7'd0, INT}, {7'd0, m_int});
      check("model_DOUT_EN", {7'd0, DOUT_EN}, {7'd0, m_den});
      if (m_den) check("model_DOUT", DOUT, m_dout);
    end
  end

  // ---------------- stimulus helpers (all start and end at a negedge) ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    CS = 0; WR = 0; A = a; DIN = d;
    tick(1);
    CS = 1; WR = 1;
    tick(1);
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [7:0] exp);
    CS = 0; RD = 0; A = a;
    tick(1);
    check(name, DOUT, exp);
    check({name, "_en"}, {7'd0, DOUT_EN}, 8'd1);
    CS = 1; RD = 1;
    tick(1);
  endtask

  task automatic pulse_ir(input logic [N-1:0] mask);
    IR = IR | mask;
    tick(1);
    IR = IR & ~mask;
    tick(1);
  endtask

  task automatic inta_seq(input string name, input logic [7:0] exp_vec);
    INTA = 0; tick(1);
    INTA = 1; tick(1);
    INTA = 0; tick(1);
    check(name, DOUT, exp_vec);
    check({name, "_en"}, {7'd0, DOUT_EN}, 8'd1);
    INTA = 1; tick(1);
    check({name, "_en_off"}, {7'd0, DOUT_EN}, 8'd0);
  endtask

  task automatic check_int(input string name, input logic exp);
    check(name, {7'd0, INT}, {7'd0, exp});
  endtask

  initial begin
    RST_N = 0; CS = 1; WR = 1; RD = 1; INTA = 1; IR = '0; A = 2'd0; DIN = 8'h00;
    tick(3);
    check("rst_INT", {7'd0, INT}, 8'd0);
    check("rst_DOUT_EN", {7'd0, DOUT_EN}, 8'd0);
    check("rst_DOUT", DOUT, 8'h00);
    chk_en = 1;
    RST_N = 1;
    tick(1);
    rd_check("rst_cfg", 2'd3, 8'h07);

    // basic fixed priority and nesting after EOI
    pulse_ir(8'h08);
    pulse_ir(8'h20);
    check_int("t1_int", 1'b1);
    inta_seq("t1_vec3", 8'h23);
    rd_check("t1_isr", 2'd1, 8'h08);
    check_int("t1_int_blocked", 1'b0);
    wr(2'd0, 8'h20);
    check_int("t1_int_ir5", 1'b1);
    inta_seq("t1_vec5", 8'h25);
    wr(2'd0, 8'h20);

    // masking does not block latching
    wr(2'd1, 8'h08);
    pulse_ir(8'h08);
    rd_check("t2_irr", 2'd0, 8'h08);
    check_int("t2_masked", 1'b0);
    wr(2'd1, 8'h00);
    check_int("t2_unmasked", 1'b1);
    inta_seq("t2_vec3", 8'h23);
    wr(2'd0, 8'h20);

    // fully nested blocking
    pulse_ir(8'h04);
    inta_seq("t4_vec2", 8'h22);
    pulse_ir(8'h20);
    check_int("t4_ir5_blocked", 1'b0);
    pulse_ir(8'h02);
    check_int("t4_ir1_nests", 1'b1);
    inta_seq("t4_vec1", 8'h21);
    rd_check("t4_isr", 2'd1, 8'h06);
    wr(2'd0, 8'h20);
    check_int("t4_still_blocked", 1'b0);
    wr(2'd0, 8'h20);
    check_int("t4_ir5_now", 1'b1);
    inta_seq("t4_vec5", 8'h25);
    wr(2'd0, 8'h20);

    // rotating priority
    wr(2'd0, 8'hC0);
    pulse_ir(8'h03);
    inta_seq("t3_vec0", 8'h20);
    wr(2'd0, 8'hA0);
    rd_check("t3_cfg", 2'd3, 8'h80);
    inta_seq("t3_vec1", 8'h21);
    pulse_ir(8'h01);
    check_int("t3_ir0_lowest", 1'b0);
    wr(2'd0, 8'h20);
    check_int("t3_ir0_ready", 1'b1);
    inta_seq("t3_vec0b", 8'h20);
    wr(2'd0, 8'h20);
    wr(2'd0, 8'h80);
    rd_check("t3_cfg_fixed", 2'd3, 8'h00);

    // spurious, specific EOI, auto-EOI
    wr(2'd2, 8'h4D);
    inta_seq("t5_spurious", 8'h4F);
    rd_check("t5_isr0", 2'd1, 8'h00);
    pulse_ir(8'h40);
    inta_seq("t5_vec6", 8'h4E);
    pulse_ir(8'h08);
    check_int("t5_ir3_nests", 1'b1);
    inta_seq("t5_vec3", 8'h4B);
    rd_check("t5_isr36", 2'd1, 8'h48);
    wr(2'd0, 8'h66);
    rd_check("t5_sp_eoi6", 2'd1, 8'h08);
    wr(2'd0, 8'h67);
    rd_check("t5_sp_eoi7_none", 2'd1, 8'h08);
    wr(2'd0, 8'h20);
    wr(2'd0, 8'hE1);
    pulse_ir(8'h10);
    inta_seq("t5_vec4", 8'h4C);
    rd_check("t5_aeoi_isr", 2'd1, 8'h00);
    rd_check("t5_cfg_aeoi", 2'd3, 8'h40);
    wr(2'd0, 8'hE0);

    // reset in the middle of a handshake
    pulse_ir(8'h04);
    INTA = 0; tick(1);
    INTA = 1; tick(1);
    RST_N = 0; tick(1);
    check("t6_rst_INT", {7'd0, INT}, 8'd0);
    check("t6_rst_DOUT_EN", {7'd0, DOUT_EN}, 8'd0);
    RST_N = 1; tick(1);
    rd_check("t6_isr", 2'd1, 8'h00);

    // level triggering
    wr(2'd0, 8'h41);
    IR[6] = 1'b1;
    tick(2);
    check_int("t6_level_int", 1'b1);
    inta_seq("t6_vec6", 8'h26);
    tick(1);
    check_int("t6_level_blocked", 1'b0);
    rd_check("t6_cfg_level", 2'd3, 8'h27);
    wr(2'd0, 8'h20);
    check_int("t6_level_reassert", 1'b1);
    IR[6] = 1'b0;
    tick(2);
    check_int("t6_level_drop", 1'b0);

    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
